// File: rtl/tennis_rng_pkg.sv
// Shared types, constants and helpers for the PRNG arbiter.
package tennis_rng_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        IDLE     = 2'd2,
        SAMPLE   = 2'd3
    } state_e;

    // An all-zero LFSR state never leaves zero, so this replaces a zero seed.
    localparam logic [15:0] FALLBACK_SEED = 16'hACE1;

    localparam int DEFAULT_MAX_TRIES = 8;

    // Smallest 2^k-1 that covers bound: smear the top set bit downwards.
    function automatic logic [7:0] bound_mask(input logic [7:0] bound);
        logic [7:0] m;
        m = bound | (bound >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after a rotating pointer.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic [IDX_W-1:0] winner_idx,
    output logic [N-1:0]     grant
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   scan_pos;
    logic [IDX_W-1:0] scan_idx;
    logic             found;

    // Move the pointer just past the requester that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (winner_idx == IDX_W'(N - 1)) ? '0 : winner_idx + IDX_W'(1);
        end
    end

    // Scan from the pointer, wrapping, and one-hot the first set request.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_pos = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_pos = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (scan_pos >= (IDX_W + 1)'(N)) begin
                scan_pos = scan_pos - (IDX_W + 1)'(N);
            end
            scan_idx = scan_pos[IDX_W-1:0];
            if (!found && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Seeds a shared 16-bit LFSR once, then serves bounded random bytes to
// round-robin requesters using masked rejection sampling.
module prng_arbiter
    import tennis_rng_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_evt,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] bound,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         data,
    output logic               seeded,
    output logic               prng_load,
    output logic [15:0]        prng_seed,
    input  logic [15:0]        prng_out
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       data_q, data_d;
    logic             seeded_q, seeded_d;
    logic             load_q, load_d;
    logic [15:0]      seed_q, seed_d;
    logic [15:0]      ent_cnt_q, ent_cnt_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [7:0]       bound_lat_q, bound_lat_d;
    logic [TRY_W-1:0] try_cnt_q, try_cnt_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [7:0]       grant_bound;
    logic             advance;
    logic [7:0]       sample_v;
    logic             in_range;
    logic             last_try;
    logic             prng_hi_unused;

    // Only the low byte of the PRNG is ever sampled.
    assign prng_hi_unused = ^prng_out[15:8];

    // A requester being acked this cycle sits out so it cannot win twice.
    assign eligible = req & ~ack_q;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (eligible),
        .advance    (advance),
        .winner_idx (win_idx_q),
        .grant      (grant)
    );

    // Encode the one-hot grant and pick out the winner's bound.
    always_comb begin
        grant_idx   = '0;
        grant_bound = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx   = IDX_W'(i);
                grant_bound = bound[8*i +: 8];
            end
        end
    end

    // Masked sample of the current PRNG value and the accept/fallback tests.
    always_comb begin
        sample_v = prng_out[7:0] & bound_mask(bound_lat_q);
        in_range = (sample_v <= bound_lat_q);
        last_try = (try_cnt_q == TRY_W'(MAX_TRIES - 1));
    end

    // Next-state logic for the seeding and sampling FSM.
    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        data_d      = data_q;
        seeded_d    = seeded_q;
        load_d      = 1'b0;
        seed_d      = seed_q;
        ent_cnt_d   = ent_cnt_q + 16'd1;
        win_idx_d   = win_idx_q;
        bound_lat_d = bound_lat_q;
        try_cnt_d   = try_cnt_q;
        advance     = 1'b0;
        case (state_q)
            UNSEEDED: begin
                if (seed_evt) begin
                    seed_d  = (ent_cnt_q == 16'd0) ? FALLBACK_SEED : ent_cnt_q;
                    load_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                seeded_d = 1'b1;
                state_d  = IDLE;
            end
            IDLE: begin
                if (|grant) begin
                    win_idx_d   = grant_idx;
                    bound_lat_d = grant_bound;
                    try_cnt_d   = '0;
                    state_d     = SAMPLE;
                end
            end
            SAMPLE: begin
                if (in_range || last_try) begin
                    data_d  = in_range ? sample_v : sample_v - (bound_lat_q + 8'd1);
                    ack_d   = N_REQ'(1) << win_idx_q;
                    advance = 1'b1;
                    state_d = IDLE;
                end else begin
                    try_cnt_d = try_cnt_q + TRY_W'(1);
                end
            end
            default: state_d = UNSEEDED;
        endcase
    end

    // All FSM state and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= UNSEEDED;
            ack_q       <= '0;
            data_q      <= '0;
            seeded_q    <= 1'b0;
            load_q      <= 1'b0;
            seed_q      <= '0;
            ent_cnt_q   <= '0;
            win_idx_q   <= '0;
            bound_lat_q <= '0;
            try_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            data_q      <= data_d;
            seeded_q    <= seeded_d;
            load_q      <= load_d;
            seed_q      <= seed_d;
            ent_cnt_q   <= ent_cnt_d;
            win_idx_q   <= win_idx_d;
            bound_lat_q <= bound_lat_d;
            try_cnt_q   <= try_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign data      = data_q;
    assign seeded    = seeded_q;
    assign prng_load = load_q;
    assign prng_seed = seed_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Randomized bench for prng_arbiter with an LFSR stand-in and a transaction-level reference model.
module tb_prng_arbiter;

    localparam int NREQ = 4;
    localparam int MAXT = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                seed_evt;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   bound;
    logic [NREQ-1:0]     ack;
    logic [7:0]          data;
    logic                seeded;
    logic                prng_load;
    logic [15:0]         prng_seed;
    logic [15:0]         prng_out;

    logic [15:0]         lfsrQ;
    bit                  forceLow = 1'b0;
    bit                  checkEn = 1'b0;
    bit                  trackSeen = 1'b0;
    logic [255:0]        seenVals = '0;

    int                  checks = 0;
    int                  passes = 0;

    // Reference model outputs
    logic [NREQ-1:0]     expAck;
    logic [7:0]          expData;
    logic                expSeeded;
    logic                expLoad;
    logic [15:0]         expSeed;

    int                  mPhase;
    logic [15:0]         mEnt;
    int                  mPtr;
    bit                  mBusy;
    int                  mCountdown;
    int                  mWin;
    logic [7:0]          mData;

    // Free-running clock
    always #5 clk = ~clk;

    prng_arbiter #(.N_REQ(NREQ), .MAX_TRIES(MAXT)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_evt  (seed_evt),
        .req       (req),
        .bound     (bound),
        .ack       (ack),
        .data      (data),
        .seeded    (seeded),
        .prng_load (prng_load),
        .prng_seed (prng_seed),
        .prng_out  (prng_out)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int maskFor(input int b);
        int m;
        m = 0;
        while (m < b) m = m * 2 + 1;
        return m;
    endfunction

    // Stand-in PRNG: Galois LFSR advancing every clock, reset from ~rst
    always @(posedge clk) begin
        if (!rst) lfsrQ <= 16'h0001;
        else if (prng_load) lfsrQ <= prng_seed;
        else lfsrQ <= lfsrStep(lfsrQ);
    end

    assign prng_out = forceLow ? {lfsrQ[15:8], 8'h07} : lfsrQ;

    // Transaction-level reference: on each grant decision compute the whole outcome up front
    always @(posedge clk) begin
        logic [NREQ-1:0] prevAck;
        logic [NREQ-1:0] elig;
        logic [15:0]     val;
        int              b, m, v, idx;
        bit              done;
        if (!rst) begin
            expAck = '0; expData = '0; expSeeded = 1'b0; expLoad = 1'b0; expSeed = '0;
            mPhase = 0; mEnt = '0; mPtr = 0; mBusy = 1'b0; mCountdown = 0; mWin = 0; mData = '0;
        end else begin
            prevAck = expAck;
            expAck  = '0;
            expLoad = 1'b0;
            if (mPhase == 0) begin
                if (seed_evt) begin
                    expSeed = (mEnt == 16'd0) ? 16'hACE1 : mEnt;
                    expLoad = 1'b1;
                    mPhase  = 1;
                end
            end else if (mPhase == 1) begin
                expSeeded = 1'b1;
                mPhase    = 2;
            end else if (mBusy) begin
                mCountdown = mCountdown - 1;
                if (mCountdown == 0) begin
                    expAck  = NREQ'(1) << mWin;
                    expData = mData;
                    mPtr    = (mWin + 1) % NREQ;
                    mBusy   = 1'b0;
                end
            end else begin
                elig = req & ~prevAck;
                if (elig != '0) begin
                    mWin = -1;
                    for (int k = 0; k < NREQ; k++) begin
                        idx = (mPtr + k) % NREQ;
                        if (mWin < 0 && elig[idx]) mWin = idx;
                    end
                    b    = int'(bound[8*mWin +: 8]);
                    m    = maskFor(b);
                    val  = lfsrQ;
                    done = 1'b0;
                    for (int t = 0; t < MAXT; t++) begin
                        if (!done) begin
                            val = lfsrStep(val);
                            v   = int'(forceLow ? 8'h07 : val[7:0]) & m;
                            if (v <= b) begin
                                mData = 8'(v); mCountdown = t + 1; done = 1'b1;
                            end else if (t == MAXT - 1) begin
                                mData = 8'(v - (b + 1)); mCountdown = t + 1; done = 1'b1;
                            end
                        end
                    end
                    mBusy = 1'b1;
                end
            end
            mEnt = mEnt + 16'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    // Every cycle, compare the DUT's outputs against the model away from the active edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ack",       32'(ack),       32'(expAck));
            checkOutput("data",      32'(data),      32'(expData));
            checkOutput("seeded",    32'(seeded),    32'(expSeeded));
            checkOutput("prng_load", 32'(prng_load), 32'(expLoad));
            checkOutput("prng_seed", 32'(prng_seed), 32'(expSeed));
        end
    end

    task automatic applyStimulus(input logic rstV, input logic seedV, input logic [NREQ-1:0] reqV);
        @(negedge clk);
        rst      = rstV;
        seed_evt = seedV;
        req      = reqV;
    endtask

    task automatic waitAck(output int lat, input int budget);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack == '0 && lat < budget);
        if (ack == '0) checkOutput("ackTimeout", 32'(lat), 32'(0));
    endtask

    task automatic resetAndSeed(input int delay);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        repeat (delay) @(negedge clk);
        seed_evt = 1'b1;
        @(negedge clk);
        seed_evt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic runRandom(input int grants, input int fixedBound, input int budget);
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < grants && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (trackSeen && ack != '0) seenVals[data] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                    got++;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    bound[8*i +: 8] = (fixedBound < 0) ? 8'($urandom_range(0, 255)) : 8'(fixedBound);
                    req[i] = 1'b1;
                end
            end
        end
        checkOutput("grantCount", 32'(got), 32'(grants));
        req = '0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int lat, cyc;
        int ackIdx[$];
        int ackCyc[$];
        int expOrder[5] = '{0, 1, 2, 3, 0};

        rst = 1'b0; seed_evt = 1'b0; req = '0; bound = '0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;

        $display("[TB] requests held while unseeded");
        bound[7:0] = 8'd255;
        applyStimulus(1'b1, 1'b0, 4'b0001);
        repeat (100) @(negedge clk);
        checkOutput("heldSeeded", 32'(seeded), 32'(0));
        checkOutput("heldAck", 32'(ack), 32'(0));

        $display("[TB] seed at entropy count 5");
        applyStimulus(1'b0, 1'b0, 4'b0001);
        applyStimulus(1'b1, 1'b0, 4'b0001);
        repeat (5) @(negedge clk);
        seed_evt = 1'b1;
        @(negedge clk);
        seed_evt = 1'b0;
        checkOutput("load5", 32'(prng_load), 32'(1));
        checkOutput("seed5", 32'(prng_seed), 32'(16'h0005));
        waitAck(lat, 20);
        checkOutput("firstAck", 32'(ack), 32'(4'b0001));
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] zero-seed substitution");
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, '0);
        @(negedge clk);
        seed_evt = 1'b0;
        checkOutput("zeroSeed", 32'(prng_seed), 32'(16'hACE1));
        @(negedge clk);

        $display("[TB] round-robin order");
        bound = {4{8'd255}};
        req   = 4'b1111;
        cyc   = 0;
        while (ackIdx.size() < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    ackIdx.push_back(i);
                    ackCyc.push_back(cyc);
                end
            end
        end
        checkOutput("rrCount", 32'(ackIdx.size()), 32'(5));
        for (int k = 0; k < ackIdx.size() && k < 5; k++)
            checkOutput("rrOrder", 32'(ackIdx[k]), 32'(expOrder[k]));
        for (int k = 1; k < ackCyc.size() && k < 5; k++)
            checkOutput("rrSpacing", 32'(ackCyc[k] - ackCyc[k-1]), 32'(2));
        req = '0;
        repeat (6) @(negedge clk);

        $display("[TB] bound 0, bound 5, random bounds");
        runRandom(50, 0, 2000);
        trackSeen = 1'b1;
        runRandom(1000, 5, 20000);
        trackSeen = 1'b0;
        checkOutput("seen0to5", 32'(seenVals[5:0]), 32'(6'h3F));
        checkOutput("seenAbove5", 32'(|seenVals[255:6]), 32'(0));
        runRandom(300, -1, 10000);

        $display("[TB] fallback path");
        resetAndSeed(3);
        forceLow   = 1'b1;
        bound[7:0] = 8'd4;
        req        = 4'b0001;
        waitAck(lat, 30);
        checkOutput("fallbackLat", 32'(lat), 32'(9));
        checkOutput("fallbackData", 32'(data), 32'(2));
        checkOutput("fallbackAck", 32'(ack), 32'(4'b0001));
        req = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset during retry");
        req = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstAck", 32'(ack), 32'(0));
        checkOutput("rstData", 32'(data), 32'(0));
        checkOutput("rstSeeded", 32'(seeded), 32'(0));
        checkOutput("rstSeed", 32'(prng_seed), 32'(0));
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("noAckAfterReset", 32'(ack), 32'(0));
        forceLow = 1'b0;
        req = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Shares one 16-bit LFSR PRNG among up to `N_REQ` game-logic requesters (serve delay, ball direction, AI paddle jitter). It seeds the PRNG once from a free-running entropy counter at the first player event. It then serves round-robin requests for bounded random bytes using masked rejection sampling. It sits between the game FSMs and the PRNG instance, and drives the PRNG's `load`/`seed` pins while consuming its `out`.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `MAX_TRIES`, 8, rejection attempts before the deterministic fallback
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-low reset; the top level drives the PRNG's reset from `~rst`
- `seed_evt`  in  1  one-cycle pulse on the first player button event (debounced)
- `req`  in  N_REQ  level request per requester, held until its `ack`
- `bound`  in  8*N_REQ  inclusive upper limit per requester, `bound[8i+7:8i]` for requester i
- `ack`  out  N_REQ  one-hot, one-cycle pulse; `data` is valid in that cycle
- `data`  out  8  random value in `0..bound` of the acked requester
- `seeded`  out  1  high once the PRNG has been loaded
- `prng_load`  out  1  to PRNG `load`
- `prng_seed`  out  16  to PRNG `seed`
- `prng_out`  in  16  from PRNG `out`, which advances every clock

## Operation
- **Reset** (`rst`=0 at an edge) gives: state UNSEEDED, `ack`=0, `data`=0, `seeded`=0, `prng_load`=0, `prng_seed`=0, `ent_cnt`=0, RR pointer=0, try count=0.
- **Entropy counter.** `ent_cnt` is 16 bits. It increments every cycle after reset and wraps 0xFFFF→0x0000.
- **UNSEEDED.**
  - Requests are held and not granted.
  - On `seed_evt`: set `prng_seed` = `ent_cnt`, or 16'hACE1 if `ent_cnt`=0, because all-zero locks the LFSR. Go to LOAD.
- **LOAD.**
  - `prng_load`=1 for exactly this cycle.
  - Go to IDLE and set `seeded`=1.
- **IDLE.**
  - If any eligible `req` is set, the round-robin winner is the first set bit at or after the pointer, wrapping.
  - Latch the winner and its `bound`, clear the try count, and go to SAMPLE.
- **SAMPLE**, once per cycle:
  - mask = smallest 2^k−1 ≥ bound; v = `prng_out[7:0]` & mask.
  - If v ≤ bound: register `data`=v, pulse `ack[winner]`, set pointer = winner+1 mod N_REQ, go to IDLE.
  - Else, if the try count = MAX_TRIES−1: deliver v−(bound+1) and ack as above.
  - Else: increment the try count and stay in SAMPLE. The PRNG has advanced, so the next cycle uses a fresh value.
- `bound`=0 gives mask 0, so the result is always 0 on the first try. `bound`=255 gives mask 0xFF and never rejects.
- **Eligibility.** In the cycle `ack[i]` is high, `req[i]` is masked from arbitration. This prevents a double grant before the requester drops `req`.
- **Ignored inputs.**
  - `seed_evt` after seeding is ignored; there is no reseed.
  - `req` bits that drop mid-SAMPLE are ignored; the grant completes.
- **Reset mid-operation** returns to UNSEEDED with every output at its reset value. Any pending grant is lost.

## Timing
- `seed_evt` at cycle t: `prng_load` high in cycle t+1; `seeded` high from t+2; the PRNG `out` equals the seed in cycle t+2.
- The first grant can enter SAMPLE no earlier than cycle t+3.
- Request to ack: `req` seen in IDLE at cycle r gives SAMPLE at r+1 and `ack` at r+2 + tries.
  - Minimum latency is 2 cycles.
  - Maximum latency is 1+MAX_TRIES cycles.
- Back-to-back: the ack cycle is IDLE, so another requester can win in that same cycle. Throughput is one grant per 2 cycles minimum.
- `data` holds its last value between acks.

## Structure
- Package `tennis_rng_pkg` holds:
  - the state enum (UNSEEDED, LOAD, IDLE, SAMPLE);
  - `FALLBACK_SEED` = 16'hACE1;
  - the default `MAX_TRIES`;
  - the mask function `bound_mask(bound)`.
- One sub-module, `rr_arbiter` (parameter N), owns:
  - inputs: `req`, `advance`, `winner_idx`;
  - output: one-hot `grant`;
  - internal state: the rotating pointer.

## Test plan
- **Held until seeded.** Hold `req`=4'b0001 with no `seed_evt` for 100 cycles → no `ack` and `seeded`=0. Then pulse `seed_evt` at `ent_cnt`=0x0005 → `prng_load`=1 for one cycle with `prng_seed`=0x0005, then `ack[0]`.
- **Zero-seed substitution.** `seed_evt` in the first cycle after reset (`ent_cnt`=0) → `prng_seed`=0xACE1.
- **Round-robin order.** All `req`=4'b1111 with `bound`=255 each → acks in order 0,1,2,3,0 at 2-cycle spacing; no requester is acked twice in a row.
- **Range bounds.** `bound`=0 → `data`=0 every time. `bound`=5 over 1000 grants → every `data` ≤5, and each of the values 0..5 is observed. Every `data` matches a reference model of LFSR plus rejection.
- **Fallback path.** Force `prng_out[7:0]`=0x07 constant with `bound`=4 → after 8 SAMPLE cycles, `data`=2 (7−5) and `ack` is asserted.
- **Reset mid-SAMPLE.** Drive `rst`=0 during a retry → the next cycle shows all outputs at reset values and state UNSEEDED; no `ack` is issued.
